// File: rtl/core_regfile_mp_if.sv
// Bundle of the register file's read, forward, write and scoreboard signals.
// master: the pipeline side that drives addresses, forwards and writes.
// slave : the register file itself (core_regfile_mp).
//   rd_latch         hold every read output
//   i_re/i_raddr     per-port read enable and address  -> o_rdata/o_busy
//   i_forward/...    forward ports, index 0 highest priority
//   i_we/...         write port
//   i_set/i_set_addr mark a destination register pending
//   o_ready          initial clear sweep finished
interface core_regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 2
);
  localparam int AW = $clog2(NREG);

  logic                           rd_latch;
  logic [NRD-1:0]                 i_re;
  logic [NRD-1:0][AW-1:0]         i_raddr;
  logic [NRD-1:0][XLEN-1:0]       o_rdata;
  logic [NRD-1:0]                 o_busy;
  logic [NFWD-1:0]                i_forward;
  logic [NFWD-1:0][AW-1:0]        i_faddr;
  logic [NFWD-1:0][XLEN-1:0]      i_fdata;
  logic                           i_we;
  logic [AW-1:0]                  i_waddr;
  logic [XLEN-1:0]                i_wdata;
  logic                           i_set;
  logic [AW-1:0]                  i_set_addr;
  logic                           o_ready;

  modport master (
    output rd_latch, i_re, i_raddr, i_forward, i_faddr, i_fdata,
           i_we, i_waddr, i_wdata, i_set, i_set_addr,
    input  o_rdata, o_busy, o_ready
  );

  modport slave (
    input  rd_latch, i_re, i_raddr, i_forward, i_faddr, i_fdata,
           i_we, i_waddr, i_wdata, i_set, i_set_addr,
    output o_rdata, o_busy, o_ready
  );
endinterface

// File: rtl/core_regfile_mp.sv
// Multi-port integer register file with forwarding and a pending-write
// scoreboard. After reset a sweep zeroes every entry (CLEAR) before the file
// reports o_ready and starts serving reads (RUN).
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - core_regfile_mp_if.slave: read ports (registered, 1-cycle latency),
//          forward ports, write port, scoreboard set port, o_ready
module core_regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 2
) (
  input  logic              clk,
  input  logic              rst,
  core_regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state, state_nx;
  logic [AW-1:0]            cnt, cnt_nx;
  logic [XLEN-1:0]          mem [NREG];
  logic [NREG-1:0]          pending, pending_nx;
  logic [NRD-1:0][XLEN-1:0] rdata_nx;
  logic [NRD-1:0]           busy_nx;
  logic                     fwd_hit;

  // FSM state and sweep counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == AW'(NREG - 1))
          state_nx = RUN;
      end
      RUN:     state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  assign bus.o_ready = (state == RUN);

  // Storage has no reset: the CLEAR sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[cnt] <= '0;
    else if (bus.i_we && bus.i_waddr != '0)
      mem[bus.i_waddr] <= bus.i_wdata;
  end

  // Scoreboard: a write clears, an issue sets; the set is applied last so a
  // same-cycle new producer wins. Entry 0 is never pending.
  always_comb begin
    pending_nx = pending;
    if (bus.i_we)
      pending_nx[bus.i_waddr] = 1'b0;
    if (bus.i_set && bus.i_set_addr != '0)
      pending_nx[bus.i_set_addr] = 1'b1;
    pending_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= '0;
    else if (state == RUN)
      pending <= pending_nx;
  end

  // Read selection per port. The write bypass is applied first and the
  // forward search then overrides it, so forwards outrank the write port and
  // the first matching forward index wins.
  always_comb begin
    rdata_nx = bus.o_rdata;
    busy_nx  = bus.o_busy;
    fwd_hit  = 1'b0;
    for (int unsigned p = 0; p < NRD; p++) begin
      if (!bus.rd_latch) begin
        if (!bus.i_re[p] || bus.i_raddr[p] == '0) begin
          rdata_nx[p] = '0;
          busy_nx[p]  = 1'b0;
        end else begin
          if (bus.i_we && bus.i_waddr == bus.i_raddr[p]) begin
            rdata_nx[p] = bus.i_wdata;
            busy_nx[p]  = 1'b0;
          end else begin
            rdata_nx[p] = mem[bus.i_raddr[p]];
            busy_nx[p]  = pending[bus.i_raddr[p]];
          end
          fwd_hit = 1'b0;
          for (int unsigned k = 0; k < NFWD; k++) begin
            if (!fwd_hit && bus.i_forward[k] && bus.i_faddr[k] == bus.i_raddr[p]) begin
              rdata_nx[p] = bus.i_fdata[k];
              busy_nx[p]  = 1'b0;
              fwd_hit     = 1'b1;
            end
          end
        end
      end
    end
  end

  // Registered read outputs, forced to zero while clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_rdata <= '0;
      bus.o_busy  <= '0;
    end else if (state == RUN) begin
      bus.o_rdata <= rdata_nx;
      bus.o_busy  <= busy_nx;
    end else begin
      bus.o_rdata <= '0;
      bus.o_busy  <= '0;
    end
  end
endmodule

// File: tb/tb_core_regfile_mp.sv
// Bench for core_regfile_mp: a reference model of the register file rules is
// compared against the DUT every cycle, and directed scenarios add literal
// expectations at key points.
module tb_core_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NFWD = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  core_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NFWD(NFWD)) bus ();

  core_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NFWD(NFWD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_pend [NREG];
  int              m_sweep;
  bit              m_ready;
  logic [XLEN-1:0] m_rdata [NRD];
  bit              m_busy  [NRD];

  initial for (int i = 0; i < NREG; i++) m_mem[i] = 32'hBAD0_0000 + i;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sweep = 0;
      m_ready = 0;
      for (int i = 0; i < NREG; i++) m_pend[i] = 0;
      for (int p = 0; p < NRD; p++) begin m_rdata[p] = 0; m_busy[p] = 0; end
    end else if (!m_ready) begin
      m_mem[m_sweep] = 0;
      m_sweep++;
      if (m_sweep == NREG) m_ready = 1;
      for (int p = 0; p < NRD; p++) begin m_rdata[p] = 0; m_busy[p] = 0; end
    end else begin
      for (int p = 0; p < NRD; p++) begin
        int a;
        bit done;
        a = int'(bus.i_raddr[p]);
        done = 0;
        if (bus.rd_latch) done = 1;
        else if (!bus.i_re[p] || a == 0) begin
          m_rdata[p] = 0; m_busy[p] = 0; done = 1;
        end
        for (int k = 0; k < NFWD; k++)
          if (!done && bus.i_forward[k] && int'(bus.i_faddr[k]) == a) begin
            m_rdata[p] = bus.i_fdata[k]; m_busy[p] = 0; done = 1;
          end
        if (!done && bus.i_we && int'(bus.i_waddr) == a) begin
          m_rdata[p] = bus.i_wdata; m_busy[p] = 0; done = 1;
        end
        if (!done) begin
          m_rdata[p] = m_mem[a]; m_busy[p] = m_pend[a];
        end
      end
      if (bus.i_we && bus.i_waddr != 0) m_mem[int'(bus.i_waddr)] = bus.i_wdata;
      if (bus.i_we) m_pend[int'(bus.i_waddr)] = 0;
      if (bus.i_set && bus.i_set_addr != 0) m_pend[int'(bus.i_set_addr)] = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("o_ready", XLEN'(bus.o_ready), XLEN'(m_ready));
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("o_rdata[%0d]", p), bus.o_rdata[p], m_rdata[p]);
      chk($sformatf("o_busy[%0d]", p), XLEN'(bus.o_busy[p]), XLEN'(m_busy[p]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.rd_latch   = 0;
    bus.i_re       = '0;
    bus.i_raddr    = '0;
    bus.i_forward  = '0;
    bus.i_faddr    = '0;
    bus.i_fdata    = '0;
    bus.i_we       = 0;
    bus.i_waddr    = '0;
    bus.i_wdata    = '0;
    bus.i_set      = 0;
    bus.i_set_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int p, input int a);
    bus.i_re[p]    = 1'b1;
    bus.i_raddr[p] = 5'(a);
  endtask

  task automatic wr(input int a, input logic [XLEN-1:0] d);
    bus.i_we    = 1'b1;
    bus.i_waddr = 5'(a);
    bus.i_wdata = d;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Release reset and check o_ready turns on exactly at the 32nd edge.
  task automatic release_and_sweep(input string tag);
    rst = 0;
    for (int i = 0; i < NREG - 1; i++) begin
      // garbage writes/issues while clearing must be ignored
      wr(9, 32'hFFFF_FFFF);
      bus.i_set = 1; bus.i_set_addr = 5'd9;
      rd(0, 9); rd(1, 9);
      bus.rd_latch = i[0];
      step();
    end
    idle();
    settle();
    chk({tag, "_ready_before"}, XLEN'(bus.o_ready), '0);
    chk({tag, "_rdata_clear"}, bus.o_rdata[0], '0);
    step();
    settle();
    chk({tag, "_ready_after"}, XLEN'(bus.o_ready), 32'd1);
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (3) step();
    settle();
    chk("rst_ready", XLEN'(bus.o_ready), '0);
    chk("rst_rdata", bus.o_rdata[1], '0);
    step();
    release_and_sweep("boot");

    // every register reads 0 after the sweep, including x9 hit during CLEAR
    for (int r = 0; r < NREG; r++) begin
      step();
      idle();
      rd(0, r); rd(1, NREG - 1 - r);
    end
    step(); idle(); rd(0, 9); step(); settle();
    chk("x9_clear_data", bus.o_rdata[0], '0);
    chk("x9_clear_busy", XLEN'(bus.o_busy[0]), '0);

    // write x5 then read it; write x0 then read it
    idle(); wr(5, 32'hDEAD_BEEF); step();
    idle(); rd(0, 5); step(); settle();
    chk("x5_read", bus.o_rdata[0], 32'hDEAD_BEEF);
    idle(); wr(0, 32'h1234_5678); rd(1, 0); step(); settle();
    chk("x0_bypass", bus.o_rdata[1], '0);
    idle(); rd(0, 0); step(); settle();
    chk("x0_read", bus.o_rdata[0], '0);

    // forward priority on x3
    idle();
    bus.i_forward = 2'b11;
    bus.i_faddr[0] = 5'd3; bus.i_fdata[0] = 32'h11;
    bus.i_faddr[1] = 5'd3; bus.i_fdata[1] = 32'h22;
    wr(3, 32'h33); rd(0, 3); rd(1, 3);
    step(); settle();
    chk("fwd0_p0", bus.o_rdata[0], 32'h11);
    chk("fwd0_p1", bus.o_rdata[1], 32'h11);
    bus.i_forward = 2'b10;
    step(); settle();
    chk("fwd1", bus.o_rdata[0], 32'h22);
    bus.i_forward = 2'b00;
    step(); settle();
    chk("wr_bypass", bus.o_rdata[1], 32'h33);

    // scoreboard on x7
    idle(); bus.i_set = 1; bus.i_set_addr = 5'd7; step();
    idle(); rd(0, 7); step(); settle();
    chk("x7_busy_set", XLEN'(bus.o_busy[0]), 32'd1);
    idle(); wr(7, 32'h5); step();
    idle(); rd(0, 7); step(); settle();
    chk("x7_data", bus.o_rdata[0], 32'h5);
    chk("x7_busy_clr", XLEN'(bus.o_busy[0]), '0);
    idle(); wr(7, 32'h9); bus.i_set = 1; bus.i_set_addr = 5'd7; step();
    idle(); rd(0, 7); rd(1, 7); step(); settle();
    chk("x7_set_wins", XLEN'(bus.o_busy[1]), 32'd1);
    chk("x7_set_data", bus.o_rdata[1], 32'h9);

    // rd_latch holds x4 across a rewrite
    idle(); wr(4, 32'hA); step();
    idle(); rd(0, 4); step(); settle();
    chk("x4_before", bus.o_rdata[0], 32'hA);
    bus.rd_latch = 1; wr(4, 32'hB);
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      chk($sformatf("x4_hold%0d", i), bus.o_rdata[0], 32'hA);
    end
    bus.rd_latch = 0; bus.i_we = 0;
    step(); settle();
    chk("x4_after", bus.o_rdata[0], 32'hB);

    // random traffic on a small address window
    for (int i = 0; i < 300; i++) begin
      step();
      idle();
      bus.rd_latch = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < NRD; p++) begin
        bus.i_re[p] = ($urandom_range(0, 5) != 0);
        bus.i_raddr[p] = 5'($urandom_range(0, 7));
      end
      for (int k = 0; k < NFWD; k++) begin
        bus.i_forward[k] = ($urandom_range(0, 3) == 0);
        bus.i_faddr[k] = 5'($urandom_range(0, 7));
        bus.i_fdata[k] = $urandom;
      end
      bus.i_we = $urandom_range(0, 1);
      bus.i_waddr = 5'($urandom_range(0, 7));
      bus.i_wdata = $urandom;
      bus.i_set = ($urandom_range(0, 2) == 0);
      bus.i_set_addr = 5'($urandom_range(0, 7));
    end

    // mid-RUN reset with a pending register being read
    step(); idle(); bus.i_set = 1; bus.i_set_addr = 5'd12; step();
    idle(); wr(13, 32'hCAFE); step();
    idle(); rd(0, 12); rd(1, 13); step(); settle();
    chk("x12_busy_pre", XLEN'(bus.o_busy[0]), 32'd1);
    chk("x13_data_pre", bus.o_rdata[1], 32'hCAFE);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("midrun_ready", XLEN'(bus.o_ready), '0);
    chk("midrun_rdata", bus.o_rdata[1], '0);
    chk("midrun_busy", XLEN'(bus.o_busy[0]), '0);
    step(); step();
    idle();
    rst = 0;
    repeat (10) step();
    #2;
    rst = 1;   // sweep counter is 10 here
    #1;
    chk("midclr_ready", XLEN'(bus.o_ready), '0);
    chk("midclr_rdata", bus.o_rdata[0], '0);
    step(); step();
    release_and_sweep("reclr");
    idle(); rd(0, 12); rd(1, 13); step(); settle();
    chk("x12_after_rst_busy", XLEN'(bus.o_busy[0]), '0);
    chk("x13_after_rst_data", bus.o_rdata[1], '0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/core_regfile_mp.md
CORE_REGFILE_MP -- requirements
Module: core_regfile_mp

Interface
REQ-001 The module SHALL have the parameter XLEN, default 32, meaning data width in bits.
REQ-002 The module SHALL have the parameter NREG, default 32, meaning register count (power of 2, >=4); AW = clog2(NREG).
REQ-003 The module SHALL have the parameter NRD, default 2, meaning number of read ports.
REQ-004 The module SHALL have the parameter NFWD, default 2, meaning number of forward ports; index 0 has the highest priority.
REQ-005 The module SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-006 The module SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 The module SHALL have port rd_latch, input, 1 bit: hold all read outputs.
REQ-009 The module SHALL have port i_re, input, NRD bits: per-port read enable.
REQ-010 The module SHALL have port i_raddr, input, NRD x AW bits: per-port read address.
REQ-011 The module SHALL have port o_rdata, output, NRD x XLEN bits: per-port read data.
REQ-012 The module SHALL have port o_busy, output, NRD bits: the addressed register awaits a pending write.
REQ-013 The module SHALL have port i_forward, input, NFWD bits: forward valid.
REQ-014 The module SHALL have port i_faddr, input, NFWD x AW bits: forward address.
REQ-015 The module SHALL have port i_fdata, input, NFWD x XLEN bits: forward data.
REQ-016 The module SHALL have port i_we, input, 1 bit: write enable.
REQ-017 The module SHALL have port i_waddr, input, AW bits: write address.
REQ-018 The module SHALL have port i_wdata, input, XLEN bits: write data.
REQ-019 The module SHALL have port i_set, input, 1 bit: issue marks i_set_addr pending.
REQ-020 The module SHALL have port i_set_addr, input, AW bits: destination of the issued instruction.
REQ-021 The module SHALL have port o_ready, output, 1 bit: initialisation complete, file usable.

Function
REQ-022 The FSM SHALL have states CLEAR and RUN; reset SHALL enter CLEAR with the sweep counter at 0.
REQ-023 In CLEAR, each cycle SHALL write 0 to entry[counter] and increment; after entry NREG-1 is written, the FSM SHALL go to RUN, so o_ready = 1 from the NREG-th edge after reset release onward.
REQ-024 In CLEAR, i_we and i_set SHALL be ignored, o_rdata SHALL be 0, o_busy SHALL be 0, and rd_latch SHALL have no effect.
REQ-025 In RUN, o_rdata[p] and o_busy[p] SHALL be registered, with 1-cycle latency from i_raddr[p].
REQ-026 Per-port read priority, highest first:
  - rd_latch: hold the previous o_rdata[p] and o_busy[p].
  - ~i_re[p] or i_raddr[p]==0: data 0, busy 0.
  - Forward k match (lowest k wins): i_fdata[k], busy 0.
  - i_we && i_waddr==i_raddr[p]: i_wdata, busy 0.
  - Otherwise: entry[i_raddr[p]], busy = pending[i_raddr[p]].
REQ-027 A write in RUN with i_we and i_waddr!=0 SHALL update the entry at the clock edge; writes to x0 SHALL be dropped.
REQ-028 The pending scoreboard SHALL hold NREG bits: i_set with i_set_addr!=0 sets the bit; i_we to an address clears it.
REQ-029 When i_set and i_we target the same address in the same cycle, the bit SHALL end set (new producer wins).
REQ-030 pending[0] SHALL always be 0.
REQ-031 All read ports SHALL be independent; identical addresses on different ports SHALL return identical results.

Reset
REQ-032 Asserting rst at any time, including mid-CLEAR or mid-RUN, SHALL immediately set o_rdata=0, o_busy=0, o_ready=0, clear all pending bits, and return the FSM to CLEAR.
REQ-033 Register contents SHALL be zeroed by the CLEAR sweep, not by rst directly.

Verification
REQ-034 Release rst with NREG=32 -> o_ready=0 for 32 cycles, then 1; every read returns 0.
REQ-035 Write x5=0xDEADBEEF, then read x5 next cycle -> 0xDEADBEEF; write to x0 followed by a read of x0 -> 0.
REQ-036 Same cycle: fwd0(x3,0x11), fwd1(x3,0x22), we(x3,0x33), read x3 -> 0x11; with fwd0 off -> 0x22; with both forwards off -> 0x33.
REQ-037 set x7, then read x7 -> busy=1; write x7=0x5 -> next read gives 0x5 with busy=0; same-cycle set+write on x7 -> busy stays 1.
REQ-038 Read x4=0xA with rd_latch=1 for 3 cycles while x4 is rewritten to 0xB -> output stays 0xA, then 0xB after release.
REQ-039 Assert rst mid-CLEAR at counter=10 -> outputs 0, sweep restarts from 0, o_ready only 32 cycles after release.
